// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-generation controller: widths, first
// public-exponent candidate and the controller state encoding.
package rsa_pkg;

  localparam int P_W = 4;
  localparam int N_W = 8;

  localparam logic [N_W-1:0] E_FIRST = 8'd3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_MUL_N   = 4'd2,
    ST_MUL_PHI = 4'd3,
    ST_E_INIT  = 4'd4,
    ST_GCD     = 4'd5,
    ST_E_NEXT  = 4'd6,
    ST_FIN     = 4'd7,
    ST_FAIL    = 4'd8
  } state_t;

endpackage

// File: rtl/fourbitmultiplier.sv
// Combinational 4x4 -> 8 unsigned shift-and-add multiplier.
// Vectors are [0:N-1] with index 0 as the MSB.
module fourbitmultiplier
  import rsa_pkg::*;
(
  input  logic [0:P_W-1] a_i,
  input  logic [0:P_W-1] b_i,
  output logic [0:N_W-1] prod_o
);

  logic [N_W-1:0] acc;

  // NOTE: always_comb uses blocking assignments and gives acc a value before
  // the loop, so no latch is inferred.
  always_comb begin
    acc = '0;
    for (int i = 0; i < P_W; i++) begin
      // b_i[P_W-1-i] carries weight 2**i because index 0 is the MSB.
      if (b_i[P_W-1-i]) begin
        acc = acc + (N_W'(a_i) << i);
      end
    end
  end

  assign prod_o = acc;

endmodule

// File: rtl/rsa_keygen_ctrl.sv
// Toy RSA key-generation controller: n = p*q, phi = (p-1)*(q-1), public e.
// Define RSA_E_SEARCH_EN to search for the smallest odd e >= 3 coprime to phi;
// otherwise e is fixed at 3 with no coprimality check.
module rsa_keygen_ctrl
  import rsa_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [0:P_W-1] p_in,
  input  logic [0:P_W-1] q_in,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [0:N_W-1] n_out,
  output logic [0:N_W-1] phi_out,
  output logic [0:N_W-1] e_out
);

  state_t         state_q, state_d;
  logic [0:P_W-1] p_q, p_d, q_q, q_d;
  logic [0:P_W-1] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [0:N_W-1] n_q, n_d, phi_q, phi_d, e_out_q, e_out_d;
  logic           busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [0:N_W-1] prod;

`ifdef RSA_E_SEARCH_EN
  logic [0:N_W-1] e_q, e_d, gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
  logic [0:N_W-1] e_nxt;
  assign e_nxt = e_q + 8'd2;
`endif

  // The single multiplier is time-shared: its operands are registered and
  // steered to (p,q) for MUL_N and to (p-1,q-1) for MUL_PHI.
  fourbitmultiplier u_mul (
    .a_i   (mul_a_q),
    .b_i   (mul_b_q),
    .prod_o(prod)
  );

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    q_d     = q_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    n_d     = n_q;
    phi_d   = phi_q;
    e_out_d = e_out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef RSA_E_SEARCH_EN
    e_d     = e_q;
    gcd_a_d = gcd_a_q;
    gcd_b_d = gcd_b_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        p_d = p_in;
        q_d = q_in;
        if (p_in < 4'd2 || q_in < 4'd2 || p_in == q_in) begin
          state_d = ST_FAIL;
        end else begin
          mul_a_d = p_in;
          mul_b_d = q_in;
          state_d = ST_MUL_N;
        end
      end
      ST_MUL_N: begin
        n_d = prod;
        // p,q >= 2 was checked in LOAD, so these cannot underflow.
        mul_a_d = p_q - 4'd1;
        mul_b_d = q_q - 4'd1;
        state_d = ST_MUL_PHI;
      end
      ST_MUL_PHI: begin
        phi_d = prod;
`ifdef RSA_E_SEARCH_EN
        state_d = ST_E_INIT;
`else
        state_d = ST_FIN;
`endif
      end
`ifdef RSA_E_SEARCH_EN
      ST_E_INIT: begin
        e_d     = E_FIRST;
        gcd_a_d = E_FIRST;
        gcd_b_d = phi_q;
        // e must lie below phi; also keeps both GCD operands non-zero.
        state_d = (E_FIRST >= phi_q) ? ST_FAIL : ST_GCD;
      end
      ST_GCD: begin
        if (gcd_a_q != gcd_b_q) begin
          if (gcd_a_q > gcd_b_q) gcd_a_d = gcd_a_q - gcd_b_q;
          else                   gcd_b_d = gcd_b_q - gcd_a_q;
        end else begin
          state_d = (gcd_a_q == 8'd1) ? ST_FIN : ST_E_NEXT;
        end
      end
      ST_E_NEXT: begin
        e_d = e_nxt;
        if (e_nxt >= phi_q) begin
          state_d = ST_FAIL;
        end else begin
          gcd_a_d = e_nxt;
          gcd_b_d = phi_q;
          state_d = ST_GCD;
        end
      end
`endif
      ST_FIN: begin
`ifdef RSA_E_SEARCH_EN
        e_out_d = e_q;
`else
        e_out_d = E_FIRST;
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_FAIL: begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      p_q     <= '0;
      q_q     <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      n_q     <= '0;
      phi_q   <= '0;
      e_out_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      q_q     <= q_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      n_q     <= n_d;
      phi_q   <= phi_d;
      e_out_q <= e_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef RSA_E_SEARCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q     <= '0;
      gcd_a_q <= '0;
      gcd_b_q <= '0;
    end else begin
      e_q     <= e_d;
      gcd_a_q <= gcd_a_d;
      gcd_b_q <= gcd_b_d;
    end
  end
`endif

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign n_out   = n_q;
  assign phi_out = phi_q;
  assign e_out   = e_out_q;

endmodule

// File: tb/tb_rsa_keygen_ctrl.sv
// Directed self-checking bench for rsa_keygen_ctrl; expectations follow
// whether RSA_E_SEARCH_EN is defined for the build.
module tb_rsa_keygen_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [0:3] p_in = '0;
  logic [0:3] q_in = '0;
  logic       busy, done, err;
  logic [0:7] n_out, phi_out, e_out;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef RSA_E_SEARCH_EN
  localparam logic [7:0] E_3_7   = 8'd5;
  localparam logic [7:0] E_15_13 = 8'd5;
  localparam int         LAT_3_7 = 16;
  localparam int         LAT_ANY = 0;
  localparam bit         DONE_2_3 = 1'b0;
  localparam int         LAT_2_3  = 5;
  localparam int         RST_DLY  = 5;
`else
  localparam logic [7:0] E_3_7   = 8'd3;
  localparam logic [7:0] E_15_13 = 8'd3;
  localparam int         LAT_3_7 = 4;
  localparam int         LAT_ANY = 4;
  localparam bit         DONE_2_3 = 1'b1;
  localparam int         LAT_2_3  = 4;
  localparam int         RST_DLY  = 2;
`endif

  always #5 clk = ~clk;

  rsa_keygen_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .p_in   (p_in),
    .q_in   (q_in),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .n_out  (n_out),
    .phi_out(phi_out),
    .e_out  (e_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"},  err,  0);
    check({tag, " n"},    n_out, 0);
    check({tag, " phi"},  phi_out, 0);
    check({tag, " e"},    e_out, 0);
  endtask

  // exp_lat of 0 skips the latency comparison; latency counts cycles after
  // the edge that samples start.
  task automatic run_case(input string tag, input logic [3:0] p, input logic [3:0] q,
                          input bit exp_done, input int exp_lat,
                          input logic [7:0] en, input logic [7:0] ephi,
                          input logic [7:0] ee, input bit restart);
    bit got_d, got_e;
    int lat;
    @(negedge clk);
    p_in  = p;
    q_in  = q;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    got_d = 1'b0;
    got_e = 1'b0;
    lat   = 0;
    for (int c = 1; c <= 400 && !(got_d || got_e); c++) begin
      @(negedge clk);
      if (done || err) begin
        got_d = done;
        got_e = err;
        lat   = c;
      end else if (restart && c == 1) begin
        start = 1'b1;
        p_in  = 4'd5;
        q_in  = 4'd11;
      end else if (restart && c == 2) begin
        start = 1'b0;
      end
    end
    check({tag, " responded"}, got_d | got_e, 1);
    check({tag, " done"}, got_d, exp_done);
    check({tag, " err"},  got_e, !exp_done);
    if (exp_lat > 0) check({tag, " latency"}, lat, exp_lat);
    check({tag, " n"},   n_out,   en);
    check({tag, " phi"}, phi_out, ephi);
    check({tag, " e"},   e_out,   ee);
    @(negedge clk);
    check({tag, " pulse_end"}, {done, err, busy}, 0);
    if (restart) begin
      repeat (3) @(negedge clk);
      check({tag, " stays_idle"}, {done, err, busy}, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("after_reset");

    run_case("p3q7",   4'd3,  4'd7,  1'b1, LAT_3_7, 8'd21,  8'd12,  E_3_7,   1'b0);
    run_case("p15q13", 4'd15, 4'd13, 1'b1, LAT_ANY, 8'd195, 8'd168, E_15_13, 1'b0);
    run_case("p5q11",  4'd5,  4'd11, 1'b1, LAT_ANY, 8'd55,  8'd40,  8'd3,    1'b0);
    run_case("p1q7",   4'd1,  4'd7,  1'b0, 2,       8'd55,  8'd40,  8'd3,    1'b0);
    run_case("p5q5",   4'd5,  4'd5,  1'b0, 2,       8'd55,  8'd40,  8'd3,    1'b0);
    run_case("p2q3",   4'd2,  4'd3,  DONE_2_3, LAT_2_3, 8'd6, 8'd2, 8'd3,    1'b0);
    run_case("busy_start", 4'd3, 4'd7, 1'b1, LAT_3_7, 8'd21, 8'd12, E_3_7,   1'b1);

    // Pull reset in the middle of a run, away from any clock edge.
    @(negedge clk);
    p_in  = 4'd3;
    q_in  = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (RST_DLY) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({"post_reset", " busy"}, busy, 0);

    run_case("fresh_p3q7", 4'd3, 4'd7, 1'b1, LAT_3_7, 8'd21, 8'd12, E_3_7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_keygen_ctrl.md
RSA_KEYGEN_CTRL -- requirements
Module: rsa_keygen_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1, request pulse; sampled only in IDLE.
REQ-004 SHALL have port p_in, input, 4, prime p; vectors are [0:N-1] with index 0 = MSB, matching fourbitmultiplier.
REQ-005 SHALL have port q_in, input, 4, prime q.
REQ-006 SHALL have port busy, output, 1, high from the cycle after an accepted start until done/err.
REQ-007 SHALL have port done, output, 1, one-cycle pulse when n_out/phi_out/e_out are valid.
REQ-008 SHALL have port err, output, 1, one-cycle pulse on rejected operands or failed e search.
REQ-009 SHALL have ports n_out, phi_out and e_out, each output, 8, modulus p*q, totient (p-1)*(q-1) and public exponent.

Function
REQ-010 SHALL time-share exactly one fourbitmultiplier instance through registered operand muxes: MUL_N feeds (p,q), MUL_PHI feeds (p-1,q-1).
REQ-011 SHALL implement states IDLE, LOAD, MUL_N, MUL_PHI, E_INIT, GCD, E_NEXT, FIN, FAIL.
REQ-012 SHALL transition IDLE->LOAD on start; LOAD captures p_in/q_in; start while busy is ignored.
REQ-013 SHALL in LOAD go to FAIL if p<2, q<2 or p==q; otherwise go to MUL_N.
REQ-014 SHALL register n_out at the end of MUL_N and phi_out at the end of MUL_PHI, one cycle each.
REQ-015 SHALL in E_INIT set candidate e=3 and load GCD operands a=e, b=phi.
REQ-016 SHALL, while in GCD with a!=b, subtract the smaller from the larger each cycle; on a==b it shall go to FIN if a==1, otherwise to E_NEXT.
REQ-017 SHALL in E_NEXT set e+=2 and go to FAIL if e>=phi, otherwise reload GCD operands (a=e, b=phi) and return to GCD.
REQ-018 SHALL in FIN drive e_out=e, pulse done for one cycle, drop busy and return to IDLE.
REQ-019 SHALL in FAIL pulse err for one cycle, drop busy, leave n_out/phi_out/e_out at their prior values and return to IDLE.
REQ-020 SHALL hold outputs stable between completions; done and err SHALL never assert in the same cycle.
REQ-021 SHALL perform all arithmetic 8-bit unsigned with no wrap; p-1 and q-1 SHALL be computed only after the LOAD check.

Reset
REQ-022 SHALL on rst_n low immediately force state IDLE with busy, done, err, n_out, phi_out and e_out all 0, including mid-GCD.
REQ-023 SHALL, after rst_n deasserts, accept start no earlier than the first rising clk edge.

Configuration
REQ-024 SHALL, with RSA_E_SEARCH_EN defined, implement the E_INIT/GCD/E_NEXT search as specified above.
REQ-025 SHALL, without RSA_E_SEARCH_EN, go MUL_PHI->FIN directly with e_out=3 and no coprimality check; done then occurs 4 cycles after start is sampled.

Structure
REQ-026 SHALL place the state enum, E_FIRST=3, P_W=4 and N_W=8 in shared package rsa_pkg.
REQ-027 SHALL use fourbitmultiplier as its only sub-module, instantiated once.

Verification
REQ-028 SHALL cover: p=3, q=7 -> n=21, phi=12, e=5 (e=3 without macro), done pulse, err=0.
REQ-029 SHALL cover: p=15, q=13 -> n=195, phi=168, e=5; p=5, q=11 -> n=55, phi=40, e=3.
REQ-030 SHALL cover: p=1, q=7 and p=q=5 -> err pulse two cycles after start, outputs unchanged.
REQ-031 SHALL cover: p=2, q=3 -> phi=2, e search fails, err with macro; without macro done with e=3.
REQ-032 SHALL cover: start re-asserted while busy -> ignored; rst_n low mid-GCD -> all outputs 0 asynchronously, then a fresh p=3, q=7 run completes correctly.
